// File: rtl/seq_mult_pkg.sv
// Shared types and defaults for the sequential shift-and-add multiplier.
// Holds the control state encoding and the default operand width.
package seq_mult_pkg;

    localparam int MULT_N_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } mult_state_e;

endpackage

// File: rtl/cla_n.sv
// N-bit carry-lookahead adder: every carry is a flat sum of generate terms
// gated by the propagate chain above it, with no ripple between bits.
module cla_n #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);

    logic [N-1:0] g;
    logic [N-1:0] pr;
    logic [N:0]   c;

    assign g  = a & b;
    assign pr = a ^ b;
    assign c[0] = ci;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_carry
            logic carry_v;
            logic prop_v;

            // c[gi+1] = g[gi] | p[gi]g[gi-1] | ... | p[gi..0]ci
            always_comb begin
                carry_v = 1'b0;
                for (int j = 0; j <= gi; j++) begin
                    prop_v = 1'b1;
                    for (int k = j + 1; k <= gi; k++) begin
                        prop_v = prop_v & pr[k];
                    end
                    carry_v = carry_v | (g[j] & prop_v);
                end
                prop_v = 1'b1;
                for (int k = 0; k <= gi; k++) begin
                    prop_v = prop_v & pr[k];
                end
                carry_v = carry_v | (prop_v & ci);
            end

            assign c[gi+1] = carry_v;
            assign s[gi]   = pr[gi] ^ c[gi];
        end
    endgenerate

    assign co = c[N];

endmodule

// File: rtl/seq_mult_n.sv
// Sequential unsigned multiplier: one conditional add plus right shift per
// cycle through cla_n, product handed off on a valid/ready interface.
module seq_mult_n
    import seq_mult_pkg::*;
#(
    parameter int N = MULT_N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] p
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    mult_state_e   state_q, state_d;
    logic [N-1:0]  mcand_q, mcand_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [N-1:0]  mq_q, mq_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [N-1:0]  addend;
    logic [N-1:0]  sum;
    logic          carry;

    assign addend = mq_q[0] ? mcand_q : '0;

    cla_n #(.N(N)) u_cla (
        .a  (acc_q),
        .b  (addend),
        .ci (1'b0),
        .s  (sum),
        .co (carry)
    );

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d = a;
                    mq_d    = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                // Carry-out drops into the top of acc; the low sum bit
                // shifts into mq as the multiplier bits retire.
                acc_d = {carry, sum[N-1:1]};
                mq_d  = {sum[0], mq_q[N-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign p         = {acc_q, mq_q};

endmodule

// File: tb/tb_seq_mult_n.sv
// Bench for seq_mult_n at N=4 (directed table, corner sequences, exhaustive
// with stalls) and N=8 (wide corner products).
module tb_seq_mult_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n4, in_valid4, in_ready4, out_valid4, out_ready4;
    logic [3:0] a4, b4;
    logic [7:0] p4;

    logic        rst_n8, in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    seq_mult_n #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n4), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4), .p(p4)
    );

    seq_mult_n #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n8), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8), .p(p8)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] sb4[$];

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        int         stall;
        bit         poke;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called #1 after an edge with dut4 in IDLE; returns #1 after the handoff edge.
    task automatic op4(input logic [3:0] a, input logic [3:0] b, input int stall,
                       input logic [7:0] exp, input bit poke);
        int edges;
        logic [7:0] want;
        check("idle_in_ready", in_ready4, 1);
        a4 = a; b4 = b; in_valid4 = 1'b1; out_ready4 = (stall == 0);
        sb4.push_back(exp);
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom);
        edges = 0;
        while (!out_valid4 && edges < 40) begin
            check("calc_in_ready", in_ready4, 0);
            @(posedge clk); #1;
            edges++;
        end
        if (!out_valid4) begin
            check("out_valid_timeout", out_valid4, 1);
            void'(sb4.pop_front());
            return;
        end
        check("latency", edges, 4);
        want = sb4[0];
        for (int i = 0; i < stall; i++) begin
            if (poke) begin
                in_valid4 = 1'b1; a4 = 4'h1; b4 = 4'h1;
            end
            check("hold_valid", out_valid4, 1);
            check("hold_p", p4, want);
            check("hold_in_ready", in_ready4, 0);
            @(posedge clk); #1;
        end
        in_valid4 = 1'b0;
        out_ready4 = 1'b1;
        check("out_valid", out_valid4, 1);
        check("product", p4, want);
        $display("op4 a=%h b=%h stall=%0d p=%h expected=%h", a, b, stall, p4, want);
        void'(sb4.pop_front());
        @(posedge clk); #1;
        out_ready4 = 1'b0;
        check("handoff_valid", out_valid4, 0);
        check("handoff_ready", in_ready4, 1);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
        int edges;
        a8 = a; b8 = b; in_valid8 = 1'b1; out_ready8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        edges = 0;
        while (!out_valid8 && edges < 60) begin
            @(posedge clk); #1;
            edges++;
        end
        check("n8_latency", edges, 8);
        check("n8_product", p8, exp);
        $display("op8 a=%h b=%h p=%h expected=%h", a, b, p8, exp);
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        check("n8_handoff", out_valid8, 0);
    endtask

    initial begin
        vecs[0] = '{a: 4'h0, b: 4'h0, stall: 0, poke: 1'b0, exp: 8'h00};
        vecs[1] = '{a: 4'hF, b: 4'hF, stall: 0, poke: 1'b0, exp: 8'hE1};
        vecs[2] = '{a: 4'hA, b: 4'h3, stall: 5, poke: 1'b1, exp: 8'h1E};
        vecs[3] = '{a: 4'h1, b: 4'hF, stall: 1, poke: 1'b0, exp: 8'h0F};
        vecs[4] = '{a: 4'h8, b: 4'h2, stall: 2, poke: 1'b0, exp: 8'h10};

        rst_n4 = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0;
        rst_n8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n4 = 1'b1; rst_n8 = 1'b1;
        check("rst_in_ready", in_ready4, 1);
        check("rst_out_valid", out_valid4, 0);
        check("rst_p", p4, 0);
        check("rst8_p", p8, 0);

        for (int i = 0; i < 5; i++) begin
            op4(vecs[i].a, vecs[i].b, vecs[i].stall, vecs[i].exp, vecs[i].poke);
            if (vecs[i].poke) begin
                for (int k = 0; k < 3; k++) begin
                    check("poke_not_captured", out_valid4, 0);
                    check("poke_idle", in_ready4, 1);
                    @(posedge clk); #1;
                end
            end
        end

        // Reset asserted on the second CALC edge abandons the operation.
        a4 = 4'h7; b4 = 4'h9; in_valid4 = 1'b1; out_ready4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        @(posedge clk); #1;
        rst_n4 = 1'b0;
        @(posedge clk); #1;
        rst_n4 = 1'b1;
        check("midrst_in_ready", in_ready4, 1);
        check("midrst_out_valid", out_valid4, 0);
        check("midrst_p", p4, 0);
        for (int k = 0; k < 6; k++) begin
            check("midrst_no_output", out_valid4, 0);
            @(posedge clk); #1;
        end
        out_ready4 = 1'b0;
        op4(4'h7, 4'h9, 0, 8'h3F, 1'b0);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                op4(4'(a), 4'(b), int'($urandom_range(0, 2)), 8'(a * b), 1'b0);
            end
        end
        check("sb_empty", sb4.size(), 0);

        op8(8'hFF, 8'hFF, 16'hFE01);
        op8(8'h80, 8'h02, 16'h0100);
        op8(8'h00, 8'hC3, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_mult_n.md
# seq_mult_n

Sequential shift-and-add unsigned multiplier built on top of the `cla_n` carry-lookahead adder. It consumes one N-bit adder per cycle to form a 2N-bit product over N iterations, trading area for latency against the combinational array multiplier. It sits directly downstream of operand sources, drives `cla_n` as its datapath stage, and hands products to the consumer over a valid/ready handshake.

## Interface
- `N`, 4, operand width in bits; N ≥ 2.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in_valid`  input  1  operand pair `a`/`b` is valid.
- `in_ready`  output  1  block can accept operands; high only in IDLE.
- `a`  input  N  multiplicand, unsigned.
- `b`  input  N  multiplier, unsigned.
- `out_valid`  output  1  `p` holds a finished product.
- `out_ready`  input  1  consumer accepts `p`.
- `p`  output  2N  product a*b, unsigned.

## Operation
- Registers: `mcand` (N), `acc` (N, high half), `mq` (N, low half / multiplier), `cnt` (ceil(log2(N))+1), `state`.
- States: IDLE, CALC, HOLD.
- IDLE: `in_ready`=1. On `in_valid && in_ready`: `mcand`←a, `mq`←b, `acc`←0, `cnt`←0, state←CALC.
- CALC: one iteration per cycle. `cla_n` computes {co,s} = `acc` + (`mq[0]` ? `mcand` : 0), ci=0. Then shift right: `acc`←{co, s[N-1:1]}, `mq`←{s[0], `mq[N-1:1]`}, `cnt`←`cnt`+1. On the iteration where `cnt`==N-1, state←HOLD.
- HOLD: `out_valid`=1, `p`={`acc`,`mq`}, held stable. On `out_ready`, state←IDLE.
- Width rule: co always lands in `acc[N-1]` after shift; no overflow possible, max product (2^N-1)^2 fits in 2N bits.
- `in_valid` in CALC/HOLD is ignored; operands are not captured and not queued.
- `a`/`b` need only be stable on the accepting edge.
- `p` is registered; outside HOLD its value is don't-care for the consumer but must not be X after reset.

## Timing
- Reset (`rst_n` low at an edge): state←IDLE, `acc`/`mq`/`mcand`/`cnt`←0. After that edge: `in_ready`=1, `out_valid`=0, `p`=0.
- Reset mid-CALC or mid-HOLD: operation abandoned, same values as above; no product is emitted.
- Latency: operands accepted at edge t0 → `out_valid`=1 after edge t0+N.
- HOLD with `out_ready` high on arrival: one-cycle `out_valid` pulse; IDLE after edge t0+N+1.
- Throughput: at best one product per N+2 cycles (accept, N iterations, handoff edge, re-accept).
- `in_ready` and `out_valid` are decoded from `state` only; no combinational path from `in_valid`/`out_ready` to any output.
- `out_valid` once high stays high and `p` unchanged until the handoff edge (backpressure-safe).

## Structure
- Shared package `seq_mult_pkg`: state enum (IDLE, CALC, HOLD), default width constant `MULT_N_DEFAULT`=4.
- One sub-module: `cla_n`, instantiated at width N, ci tied 0, as the sole adder; no `+` operator in the datapath.
- Control FSM and shift datapath live in `seq_mult_n` itself.

## Test plan
- Reset then a=0x0, b=0x0 → `out_valid` after 4 cycles, p=0x00; `in_ready`=1 and `out_valid`=0 straight after reset.
- a=0xF, b=0xF, `out_ready` held 1 → p=0xE1 exactly 4 edges after accept, `out_valid` one cycle, back in IDLE next edge.
- a=0xA, b=0x3, `out_ready` low for 5 cycles in HOLD → p=0x1E stable and `out_valid` high throughout; new `in_valid` with a=0x1,b=0x1 ignored (`in_ready`=0).
- a=0x7, b=0x9, `rst_n` low on 2nd CALC edge → state IDLE, p=0x00, `out_valid` never asserts; next op a=0x7,b=0x9 → p=0x3F.
- Exhaustive a,b ∈ 0..15 back-to-back with random `out_ready` stalls → every p equals golden a*b, no dropped or duplicated products, `in_ready` never high outside IDLE.
- N=8: a=0xFF, b=0xFF → p=0xFE01 after 8 cycles; a=0x80, b=0x02 → p=0x0100.
